// File: rtl/dma_peripheral_endpoint.sv
// 8237-style peripheral DMA endpoint with an 8x8 FIFO between the bus and the local side.
// Latency: DREQ is asserted in the first ARMED cycle; the FIFO is updated in the single RELEASE cycle.
// Backpressure: DREQ is withheld while the FIFO cannot serve; wr_ready/rd_valid expose FIFO space/data.
// Optional macro DMA_EP_EOP_OUT_EN drives EOP_N_DRV on the terminal-count RELEASE cycle.
module dma_peripheral_endpoint (
    input  logic        CLK,
    input  logic        RESET,
    output logic        DREQ,
    input  logic        DACK,
    input  logic        IOR_N,
    input  logic        IOW_N,
    input  logic [7:0]  DB_IN,
    output logic [7:0]  DB_OUT,
    output logic        DB_OE,
    input  logic        EOP_N_IN,
    output logic        EOP_N_DRV,
    input  logic        cfg_dir,
    input  logic [15:0] cfg_count,
    input  logic        cfg_start,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done,
    output logic        tc
);

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_ARMED   = 5'b00010,
        ST_XFER    = 5'b00100,
        ST_RELEASE = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

    state_t      state_q, state_d;
    logic        dir_q, dir_d;
    logic [15:0] rem_q, rem_d;
    logic [7:0]  hold_q, hold_d;
    logic        tc_q, tc_d;
    logic [7:0]  mem_q [8];
    logic [7:0]  mem_d [8];
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        full, empty, strobe_n, abort, loc_dir;
    logic        dreq_c, done_c, bus_push, bus_pop;
    logic        push_loc, pop_loc, do_push, do_pop;
    logic [7:0]  push_dat;

    assign full     = (cnt_q == 4'd8);
    assign empty    = (cnt_q == 4'd0);
    assign strobe_n = dir_q ? IOW_N : IOR_N;
    assign abort    = ~EOP_N_IN;
    // Before a transfer is started the local side follows cfg_dir so the FIFO can be primed.
    assign loc_dir  = (state_q == ST_IDLE) ? cfg_dir : dir_q;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        rem_d    = rem_q;
        hold_d   = hold_q;
        tc_d     = tc_q;
        dreq_c   = 1'b0;
        done_c   = 1'b0;
        bus_push = 1'b0;
        bus_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    dir_d   = cfg_dir;
                    rem_d   = cfg_count;
                    tc_d    = 1'b0;
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                dreq_c = dir_q ? ~full : ~empty;
                if (abort) begin
                    state_d = ST_DONE;
                end else if (DACK && !strobe_n) begin
                    state_d = ST_XFER;
                    if (dir_q) hold_d = DB_IN;
                end
            end
            ST_XFER: begin
                if (dir_q && DACK && !IOW_N) hold_d = DB_IN;
                if (abort) begin
                    state_d = ST_DONE;
                end else if (strobe_n) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                bus_pop  = ~dir_q;
                bus_push = dir_q;
                if (abort) begin
                    state_d = ST_DONE;
                end else if (rem_q == 16'd0) begin
                    tc_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    rem_d   = rem_q - 16'd1;
                    state_d = ST_ARMED;
                end
            end
            ST_DONE: begin
                done_c  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus and local sides never pop (or push) in the same cycle: their roles are complementary.
    always_comb begin
        push_loc = ~loc_dir & wr_valid & ~full;
        pop_loc  = loc_dir & rd_ready & ~empty;
        do_pop   = (bus_pop | pop_loc) & ~empty;
        do_push  = (bus_push | push_loc) & (~full | do_pop);
        push_dat = bus_push ? hold_q : wr_data;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 3'd1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 3'd1;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            rem_q    <= 16'd0;
            hold_q   <= 8'd0;
            tc_q     <= 1'b0;
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            rem_q    <= rem_d;
            hold_q   <= hold_d;
            tc_q     <= tc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    assign DREQ     = ~RESET & dreq_c;
    assign DB_OE    = ~RESET & (state_q == ST_XFER) & ~dir_q & DACK & ~IOR_N;
    assign DB_OUT   = DB_OE ? mem_q[rd_ptr_q] : 8'h00;
    assign busy     = ~RESET & (state_q != ST_IDLE);
    assign done     = ~RESET & done_c;
    assign tc       = ~RESET & tc_q;
    assign wr_ready = RESET | ~full;
    assign rd_valid = ~RESET & ~empty;
    assign rd_data  = mem_q[rd_ptr_q];

`ifdef DMA_EP_EOP_OUT_EN
    assign EOP_N_DRV = ~RESET & (state_q == ST_RELEASE) & (rem_q == 16'd0);
`else
    assign EOP_N_DRV = 1'b0;
`endif

endmodule

// File: tb/tb_dma_peripheral_endpoint.sv
// Bench for dma_peripheral_endpoint: scenario table, randomized scenarios and hand-written corner sequences,
// checked against a byte-queue model of the FIFO and the transfer-count rules.
module tb_dma_peripheral_endpoint;

    logic        CLK = 1'b0;
    logic        RESET, DACK, IOR_N, IOW_N, EOP_N_IN;
    logic [7:0]  DB_IN, DB_OUT, wr_data, rd_data;
    logic        DREQ, DB_OE, EOP_N_DRV;
    logic        cfg_dir, cfg_start, wr_valid, wr_ready, rd_valid, rd_ready, busy, done, tc;
    logic [15:0] cfg_count;

    dma_peripheral_endpoint dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .DB_IN(DB_IN), .DB_OUT(DB_OUT), .DB_OE(DB_OE), .EOP_N_IN(EOP_N_IN), .EOP_N_DRV(EOP_N_DRV),
        .cfg_dir(cfg_dir), .cfg_count(cfg_count), .cfg_start(cfg_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .busy(busy), .done(done), .tc(tc)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq[$];
    bit         prev_tc = 1'b0;

    typedef struct {
        bit         dir;
        int         preload;
        int         count;
        int         eop_after;
        bit         exp_tc;
        int         exp_xfers;
        logic [7:0] base;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_dreq", DREQ, 0);
        chk("rst_db_oe", DB_OE, 0);
        chk("rst_db_out", DB_OUT, 0);
        chk("rst_eop_drv", EOP_N_DRV, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tc", tc, 0);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_rd_valid", rd_valid, 0);
    endtask

    task automatic do_reset();
        RESET = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N_IN = 1'b1;
        cfg_start = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        tick();
        tick();
        chk_reset_outputs();
        RESET = 1'b0;
        tick();
        mq.delete();
        prev_tc = 1'b0;
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        cfg_dir = 1'b0;
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = (base != 8'h00) ? base + 8'(i) : 8'($urandom);
            #1;
            chk("wr_ready_fill", wr_ready, (mq.size() < 8) ? 1 : 0);
            tick();
            mq.push_back(wr_data);
        end
        wr_valid = 1'b0;
        #1;
        chk("wr_ready_after_fill", wr_ready, (mq.size() < 8) ? 1 : 0);
    endtask

    // One bus cycle in the latched direction; leaves the DUT just past the RELEASE cycle.
    task automatic bus_xfer(input bit dir, input logic [7:0] d_in, input bit fixed, input bit last);
        logic [7:0] d;
        int         hold;
        d    = d_in;
        hold = fixed ? 0 : int'($urandom_range(0, 2));
        chk("dreq_armed", DREQ, 1);
        DACK = 1'b1;
        if (dir) begin
            IOW_N = 1'b0;
            DB_IN = d;
        end else begin
            IOR_N = 1'b0;
        end
        tick();
        chk("dreq_xfer", DREQ, 0);
        chk("db_oe_xfer", DB_OE, dir ? 0 : 1);
        if (!dir) chk("db_out", DB_OUT, (mq.size() > 0) ? mq[0] : 8'h00);
        for (int h = 0; h < hold; h++) begin
            if (dir) begin
                d     = 8'($urandom);
                DB_IN = d;
            end
            tick();
            if (!dir) chk("db_out_hold", DB_OUT, (mq.size() > 0) ? mq[0] : 8'h00);
        end
        IOR_N = 1'b1;
        IOW_N = 1'b1;
        DB_IN = 8'($urandom);
        #1;
        chk("db_oe_strobe_high", DB_OE, 0);
        tick();
        DACK = 1'b0;
        #1;
        chk("dreq_release", DREQ, 0);
`ifdef DMA_EP_EOP_OUT_EN
        chk("eop_drv_release", EOP_N_DRV, last ? 1 : 0);
`else
        chk("eop_drv_release", EOP_N_DRV, 0);
`endif
        tick();
        if (dir) mq.push_back(d);
        else if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic drain();
        int         n;
        int         exp_n;
        logic [7:0] exp_b;
        n       = 0;
        exp_n   = mq.size();
        cfg_dir = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            if (!rd_valid) break;
            exp_b = (mq.size() > 0) ? mq.pop_front() : 8'h00;
            chk("drain_data", rd_data, exp_b);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            #1;
            n++;
        end
        chk("drain_count", n, exp_n);
        mq.delete();
    endtask

    task automatic run_scn(input vec_t v);
        logic [7:0] d;
        if (!v.dir) preload(v.preload, v.base);
        cfg_dir = v.dir;
        #1;
        chk("tc_held_idle", tc, prev_tc);
        cfg_count = 16'(v.count);
        cfg_start = 1'b1;
        tick();
        chk("busy_start", busy, 1);
        chk("tc_clear_start", tc, 0);
        cfg_count = 16'd0;
        tick();
        cfg_start = 1'b0;
        for (int k = 1; k <= v.exp_xfers; k++) begin
            d = (v.base != 8'h00) ? v.base + 8'(k - 1) : 8'($urandom);
            bus_xfer(v.dir, d, v.base != 8'h00, k == v.count + 1);
        end
        if (v.eop_after != 0) begin
            EOP_N_IN = 1'b0;
            tick();
            EOP_N_IN = 1'b1;
            #1;
        end
        chk("done_pulse", done, 1);
        chk("tc_done", tc, v.exp_tc);
        chk("dreq_done", DREQ, 0);
        tick();
        chk("done_low", done, 0);
        chk("busy_idle", busy, 0);
        chk("tc_idle", tc, v.exp_tc);
        prev_tc = v.exp_tc;
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          dir pre cnt eop tc xf  base
        vt[0] = '{1'b0, 3, 2, 0, 1'b1, 3, 8'hA1};
        vt[1] = '{1'b1, 0, 0, 0, 1'b1, 1, 8'h5C};
        vt[2] = '{1'b0, 8, 9, 3, 1'b0, 3, 8'h00};
        vt[3] = '{1'b0, 6, 0, 0, 1'b1, 1, 8'h00};
        vt[4] = '{1'b1, 0, 3, 0, 1'b1, 4, 8'h00};
        vt[5] = '{1'b1, 0, 7, 2, 1'b0, 2, 8'h00};
        vt[6] = '{1'b0, 5, 4, 0, 1'b1, 5, 8'h00};

        cfg_dir = 1'b0; cfg_count = 16'd0; DB_IN = 8'h00; wr_data = 8'h00;
        do_reset();

        for (int i = 0; i < 7; i++) run_scn(vt[i]);

        // Randomized scenarios; expectations follow the count/abort rules directly.
        for (int r = 0; r < 12; r++) begin
            vec_t v;
            v.dir       = 1'($urandom);
            v.count     = int'($urandom_range(0, 7));
            v.preload   = v.dir ? 0 : int'($urandom_range(v.count + 1, 8));
            v.eop_after = (v.count > 0 && ($urandom % 3) == 0) ? int'($urandom_range(1, v.count)) : 0;
            v.exp_xfers = (v.eop_after != 0) ? v.eop_after : v.count + 1;
            v.exp_tc    = (v.eop_after == 0);
            v.base      = 8'h00;
            run_scn(v);
        end

        // Full FIFO in memory-to-device mode withholds DREQ until the local side pops.
        do_reset();
        cfg_dir   = 1'b1;
        cfg_count = 16'd15;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) bus_xfer(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("full_dreq", DREQ, 0);
        chk("full_wr_ready", wr_ready, 0);
        tick();
        chk("full_dreq_hold", DREQ, 0);
        chk("full_rd_data", rd_data, mq[0]);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        void'(mq.pop_front());
        #1;
        chk("dreq_after_pop", DREQ, 1);
        bus_xfer(1'b1, 8'($urandom), 1'b0, 1'b0);
        chk("refull_dreq", DREQ, 0);

        // Strobes without DACK, DACK loss in XFER, then reset mid-transfer.
        do_reset();
        preload(2, 8'h00);
        cfg_count = 16'd1;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        DACK  = 1'b0;
        IOR_N = 1'b0;
        #1;
        chk("nodack_db_oe", DB_OE, 0);
        tick();
        chk("nodack_db_oe2", DB_OE, 0);
        chk("nodack_dreq", DREQ, 1);
        IOR_N = 1'b1;
        tick();
        chk("nodack_rd_data", rd_data, mq[0]);
        DACK  = 1'b1;
        IOR_N = 1'b0;
        tick();
        chk("xfer_db_oe", DB_OE, 1);
        DACK = 1'b0;
        #1;
        chk("xfer_dack_low_db_oe", DB_OE, 0);
        RESET = 1'b1;
        tick();
        chk_reset_outputs();
        RESET = 1'b0;
        IOR_N = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rd_valid", rd_valid, 0);
        tick();
        chk("post_rst_done2", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_peripheral_endpoint.md
DMA_PERIPHERAL_ENDPOINT -- requirements
Module: dma_peripheral_endpoint

Interface
REQ-001 SHALL have one clock, CLK, and a synchronous, active-high reset, RESET; all state updates on posedge CLK.
REQ-002 SHALL have ports: CLK in 1 clock; RESET in 1 sync reset; DREQ out 1 DMA request; DACK in 1 acknowledge (active high); IOR_N in 1 I/O read strobe; IOW_N in 1 I/O write strobe; DB_IN in 8 bus data in; DB_OUT out 8 bus data out; DB_OE out 1 bus drive enable; EOP_N_IN in 1 sampled EOP line; EOP_N_DRV out 1 open-drain EOP pull-low.
REQ-003 SHALL have local ports: cfg_dir in 1 (0 = device-to-memory, supplies data on IOR_N; 1 = memory-to-device, accepts data on IOW_N); cfg_count in 16 (transfers minus one); cfg_start in 1; wr_valid in 1, wr_data in 8, wr_ready out 1 (local push); rd_valid out 1, rd_data out 8, rd_ready in 1 (local pop); busy out 1; done out 1 (pulse); tc out 1 (terminal-count status).

Function
REQ-004 SHALL contain an 8-entry x 8-bit FIFO: bus side pops (dir 0) or pushes (dir 1); local side pushes (dir 0) or pops (dir 1); wr_ready = not full, rd_valid = not empty; simultaneous push and pop SHALL both occur; full with pop-and-push SHALL keep count.
REQ-005 SHALL implement FSM IDLE, ARMED, XFER, RELEASE, DONE; one-hot encoded.
REQ-006 IDLE: cfg_start=1 -> latch cfg_dir, load remaining = cfg_count (16 bits), busy=1, go ARMED; cfg_start while not IDLE SHALL be ignored.
REQ-007 ARMED: DREQ=1 iff (dir 0 and FIFO not empty) or (dir 1 and FIFO not full); DACK=1 with active strobe sampled low -> XFER.
REQ-008 XFER: DREQ=0; dir 0: DB_OUT = FIFO head, DB_OE=1 while DACK=1 and IOR_N=0; dir 1: DB_IN captured into holding register every cycle IOW_N=0; strobe sampled high -> RELEASE.
REQ-009 RELEASE (one cycle): dir 0 pops FIFO, dir 1 pushes holding register; remaining==0 -> tc=1, DONE; else remaining decrements by 1, ARMED.
REQ-010 Transfer count SHALL be cfg_count+1; cfg_count=16'hFFFF SHALL yield 65536 transfers; no wrap-around beyond terminal count.
REQ-011 EOP_N_IN sampled low in ARMED, XFER or RELEASE SHALL abort: a RELEASE in progress completes its FIFO update, then DONE with tc=0; the FIFO is not flushed.
REQ-012 DONE (one cycle): done=1, DREQ=0, then IDLE with busy=0; tc holds until next cfg_start.
REQ-013 DB_OE SHALL be 0 whenever DACK=0, in any state; strobes without DACK SHALL be ignored.
REQ-014 Latency: DREQ rises the cycle after entering ARMED with condition true; next DREQ no earlier than 2 cycles after strobe release.

Reset
REQ-015 RESET=1 SHALL force IDLE, empty the FIFO, and clear remaining, holding register and tc.
REQ-016 Output values under reset: DREQ=0, DB_OE=0, DB_OUT=0, EOP_N_DRV=0, busy=0, done=0, tc=0, wr_ready=1, rd_valid=0.
REQ-017 RESET mid-transfer SHALL abort without a done pulse; the next cycle with RESET=0 SHALL be IDLE.

Configuration
REQ-018 Macro DMA_EP_EOP_OUT_EN: when defined, EOP_N_DRV=1 (pull line low) for exactly the RELEASE cycle in which remaining==0, signalling terminal count to the controller; when undefined, EOP_N_DRV SHALL be tied 0 and termination is by count or EOP_N_IN only.

Verification
REQ-019 dir 0, cfg_count=2, push 0xA1,0xA2,0xA3; three DACK+IOR_N pulses -> DB_OUT reads A1,A2,A3, DREQ drops each XFER, done pulse, tc=1, FIFO empty.
REQ-020 dir 1, cfg_count=0, single DACK+IOW_N with DB_IN=0x5C -> rd_data=0x5C, rd_valid=1, done one cycle after RELEASE; with DMA_EP_EOP_OUT_EN, EOP_N_DRV=1 in that RELEASE.
REQ-021 dir 1, FIFO filled to 8, rd_ready=0 -> DREQ=0; pop one -> DREQ=1 next cycle.
REQ-022 dir 0, cfg_count=9, EOP_N_IN low after 3rd transfer -> done, tc=0, remaining FIFO data retained, busy=0.
REQ-023 IOR_N pulse with DACK=0 -> DB_OE stays 0, FIFO unchanged; RESET during XFER -> DREQ=0, FIFO empty, no done.
